// File: rtl/reg_slice_skid_if.sv
// reg_slice_skid_if: producer/consumer handshake bundle for the skid register slice
interface reg_slice_skid_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/reg_slice_skid.sv
// reg_slice_skid: two-entry valid/ready register slice; every output comes straight from flops
module reg_slice_skid #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   reg_slice_skid_if.slave       bus,
   output logic [1:0]            occupancy
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] main_q, skid_q, main_d;
   logic             main_en, skid_en, in_fire, out_fire;
   assign in_fire  = bus.in_valid & (state != FULL);
   assign out_fire = (state != EMPTY) & bus.out_ready;
   always_comb begin
      state_nxt = state;
      main_en   = 1'b0;
      skid_en   = 1'b0;
      main_d    = bus.in_data;
      case (state)
         EMPTY: if (in_fire) begin
            state_nxt = ONE;
            main_en   = 1'b1;
         end
         ONE: begin
            main_en   = in_fire & out_fire;
            skid_en   = in_fire & ~out_fire;
            state_nxt = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE;
         end
         FULL: if (out_fire) begin
            state_nxt = ONE;
            main_en   = 1'b1;
            main_d    = skid_q;
         end
         default: state_nxt = EMPTY;
      endcase
      // flush only drops occupancy; data registers may still load as don't-care
      if (flush) state_nxt = EMPTY;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= INIT;
         skid_q <= INIT;
      end else begin
         state <= state_nxt;
         if (main_en) main_q <= main_d;
         if (skid_en) skid_q <= bus.in_data;
      end
   end
   assign bus.out_valid = (state != EMPTY);
   assign bus.in_ready  = (state != FULL);
   assign bus.out_data  = main_q;
   assign occupancy     = state;
endmodule

// File: tb/tb_reg_slice_skid.sv
// tb_reg_slice_skid: scoreboard bench for reg_slice_skid (order, loss, stability, flush, reset)
module tb_reg_slice_skid;
   localparam int          WIDTH = 32;
   localparam logic [31:0] INIT  = 32'hDEAD_BEEF;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  occupancy;
   logic [31:0] q[$];
   logic [31:0] stall_data;
   logic        stall_prev = 1'b0;
   int          n_chk = 0, n_pass = 0, n_in = 0, cyc = 0;
   reg_slice_skid_if #(.WIDTH(WIDTH)) bus ();
   reg_slice_skid #(.WIDTH(WIDTH), .INIT(INIT)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave), .occupancy(occupancy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic cycle();
      @(negedge clk);
      check("occ", 32'(occupancy), 32'(q.size()));
      if (stall_prev) begin
         check("hold_v", 32'(bus.out_valid), 32'd1);
         check("hold_d", bus.out_data, stall_data);
      end
      stall_prev = bus.out_valid & ~bus.out_ready & ~flush;
      stall_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) check("spurious", 32'd1, 32'd0);
         else check("data", bus.out_data, q.pop_front());
      end
      if (bus.in_valid && bus.in_ready && !flush) begin
         q.push_back(bus.in_data);
         n_in++;
      end
      if (flush) q.delete();
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      flush         = f;
   endtask
   initial begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_data", bus.out_data, INIT);
      rst_n = 1'b1;
      // streaming 1..100 at full rate
      for (int i = 1; i <= 100; i++) begin
         drive(1'b1, 32'(i), 1'b1, 1'b0);
         if (i > 1) begin
            check("stream_ready", 32'(bus.in_ready), 32'd1);
            check("stream_occ", 32'(occupancy), 32'd1);
            check("stream_out", bus.out_data, 32'(i - 1));
         end
         cycle();
      end
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      cycle();
      check("stream_drain", 32'(occupancy), 32'd0);
      // stall and skid
      drive(1'b1, 32'hA, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 32'hB, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 32'hC, 1'b0, 1'b0);
      check("skid_ready", 32'(bus.in_ready), 32'd0);
      check("skid_occ", 32'(occupancy), 32'd2);
      check("skid_main", bus.out_data, 32'hA);
      cycle();
      drive(1'b1, 32'hC, 1'b1, 1'b0);
      cycle();
      check("skid_ready_back", 32'(bus.in_ready), 32'd1);
      check("skid_next", bus.out_data, 32'hB);
      cycle();
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      cycle();
      cycle();
      check("skid_empty", 32'(q.size()), 32'd0);
      // flush from FULL with a beat offered
      drive(1'b1, 32'h1, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 32'h2, 1'b0, 1'b0);
      cycle();
      check("fl_full", 32'(occupancy), 32'd2);
      drive(1'b1, 32'h3, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("fl_valid", 32'(bus.out_valid), 32'd0);
      check("fl_occ", 32'(occupancy), 32'd0);
      repeat (4) cycle();
      // flush together with out_fire delivers the held beat
      drive(1'b1, 32'h5, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 32'd0, 1'b1, 1'b1);
      check("flf_data", bus.out_data, 32'h5);
      cycle();
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      check("flf_occ", 32'(occupancy), 32'd0);
      cycle();
      // random backpressure
      n_in = 0;
      cyc = 0;
      while (n_in < 10000 && cyc < 60000) begin
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         cycle();
      end
      check("rand_budget", 32'(n_in >= 10000), 32'd1);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      repeat (4) cycle();
      check("rand_drained", 32'(q.size()), 32'd0);
      // asynchronous reset while FULL
      drive(1'b1, 32'h11, 1'b0, 1'b0);
      cycle();
      drive(1'b1, 32'h22, 1'b0, 1'b0);
      cycle();
      check("ar_full", 32'(occupancy), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(bus.out_valid), 32'd0);
      check("ar_ready", 32'(bus.in_ready), 32'd1);
      check("ar_occ", 32'(occupancy), 32'd0);
      check("ar_data", bus.out_data, INIT);
      q.delete();
      stall_prev = 1'b0;
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 32'h77, 1'b1, 1'b0);
      cycle();
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      cycle();
      check("ar_after", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/reg_slice_skid.md
Name: reg_slice_skid

Overview:
Two-entry valid/ready register slice with a skid buffer. It sits between a producer and a consumer and breaks the timing paths on both sides: the forward path (valid/data) and the backward path (ready). Each stage uses enabled, async-reset data flops. It sustains one transfer per cycle under continuous flow and absorbs one extra beat when the consumer stalls.

Parameters:
WIDTH, 32, payload width in bits.
INIT, {WIDTH{1'b0}}, reset value of both data registers and therefore of out_data.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous discard of all held beats.
in_valid  input  1  producer has a beat.
in_ready  output  1  slice accepts a beat this cycle.
in_data  input  WIDTH  producer payload.
out_valid  output  1  slice presents a beat.
out_ready  input  1  consumer accepts a beat this cycle.
out_data  output  WIDTH  payload presented to the consumer.
occupancy  output  2  number of held beats: 0, 1 or 2.

Behaviour:
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register. Each register loads only when its enable is asserted; otherwise it holds.
- State machine: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - occupancy is encoded directly from the state.
  - All outputs are decoded from flops only; there is no combinational path from in_valid or out_ready to any output.
- Reset (rst_n low, asynchronous):
  - state = EMPTY, out_valid = 0, in_ready = 1, occupancy = 0.
  - main = skid = INIT, so out_data = INIT.
  - Reset asserted mid-transfer drops all held beats immediately.
- Transitions (flush = 0):
  - EMPTY: in_fire -> ONE, main <= in_data. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main <= in_data (pass-through, full throughput).
  - ONE, in_fire & !out_ready -> FULL, skid <= in_data, main holds.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, no fire -> hold.
  - FULL: in_ready = 0, so in_valid is ignored. out_fire -> ONE, main <= skid. Otherwise hold.
- Flush (flush = 1, synchronous, highest priority below reset):
  - Next state = EMPTY regardless of the current state.
  - A beat offered with in_fire in a flush cycle is dropped; its data registers may load but are don't-care.
  - An out_fire in a flush cycle counts as delivered to the consumer.
  - Data registers are not cleared by flush.
- Latency:
  - in_fire to out_valid: 1 cycle.
  - out_fire in FULL to in_ready high: 1 cycle.
- Ordering: beats leave in strict arrival order. No beat is ever duplicated or lost except by flush or reset.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid must not change, unless flush or reset is asserted.
- Data width rule: payload is carried bit-exact with no transformation. WIDTH must be at least 1.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with state FULL -> out_valid = 0, in_ready = 1 and occupancy = 0 asynchronously; with INIT = 32'hDEAD_BEEF, out_data = 32'hDEAD_BEEF.
- Streaming: in_valid = 1 with data 1..100 on consecutive cycles and out_ready = 1 throughout -> out_data shows 1..100 on consecutive cycles starting 1 cycle after the first in_fire; in_ready stays 1 and occupancy stays 1.
- Stall/skid: stream 0xA, 0xB, 0xC while out_ready = 0 from cycle 1 -> 0xA held in main, 0xB captured in skid, in_ready = 0 when 0xC is offered, occupancy = 2. Then release out_ready -> outputs 0xA, 0xB, 0xC in order and in_ready returns to 1 one cycle after the first out_fire.
- Random backpressure: 10k beats with random in_valid and out_ready at 50% -> scoreboard shows in-order, lossless delivery; output stability holds on every stalled cycle; occupancy always equals beats in minus beats out.
- Flush: in FULL holding 0x1 and 0x2, assert flush = 1 with in_valid = 1 (data 0x3) and out_ready = 0 -> next cycle out_valid = 0, occupancy = 0, and none of 0x1, 0x2, 0x3 ever appear on the output.
- Flush with out_fire: in ONE holding 0x5, assert flush and out_ready together -> 0x5 counts as delivered and the state is EMPTY on the next cycle.
